sequential_divider: RTL and testbench



---
 rtl/sequential_divider_if.sv | 24 ++
 rtl/sequential_divider.sv | 114 +++++++++++
 tb/tb_sequential_divider.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sequential_divider_if.sv
// rtl/sequential_divider_if.sv - request/result bundle between a divider client and the divider
interface sequential_divider_if #(
    parameter int DW = 8,
    parameter int VW = 4
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - restoring shift-subtract unsigned divider, one quotient bit per cycle
module sequential_divider #(
    parameter int DW = 8,
    parameter int VW = 4
) (
    input  logic                clk,
    input  logic                rst,
    sequential_divider_if.slave bus
);
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_DIVIDE,
        S_DONE
    } state_t;

    state_t        r_state;
    logic          r_accept;
    logic [DW-1:0] r_dvd;
    logic [VW-1:0] r_dvs;
    logic [VW:0]   r_rem;
    logic [CW-1:0] r_cnt;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_remd;
    logic          r_busy;
    logic          r_done;
    logic          r_dbz;

    logic [VW:0]   w_rem_sh;
    logic          w_ge;
    logic [VW:0]   w_rem_nx;
    logic [DW-1:0] w_dvd_nx;

    // The dividend register doubles as the quotient: its MSB shifts into the
    // partial remainder while each new quotient bit enters at the LSB.
    assign w_rem_sh = (r_rem << 1) | {{VW{1'b0}}, r_dvd[DW-1]};
    assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
    assign w_rem_nx = w_ge ? (w_rem_sh - {1'b0, r_dvs}) : w_rem_sh;
    assign w_dvd_nx = {r_dvd[DW-2:0], w_ge};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_accept <= 1'b0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_rem    <= '0;
            r_cnt    <= '0;
            r_quot   <= '0;
            r_remd   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dbz    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Operands are latched on the accepting edge so later input
                    // changes cannot leak in; INIT follows on the next edge.
                    if (r_accept) begin
                        r_accept <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_INIT;
                    end else if (bus.start) begin
                        r_accept <= 1'b1;
                        r_dvd    <= bus.dividend;
                        r_dvs    <= bus.divisor;
                    end
                end
                S_INIT: begin
                    r_rem <= '0;
                    r_cnt <= CW'(DW);
                    if (r_dvs == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= '1;
                        r_remd  <= '0;
                        r_dbz   <= 1'b1;
                    end else begin
                        r_state <= S_DIVIDE;
                    end
                end
                S_DIVIDE: begin
                    r_rem <= w_rem_nx;
                    r_dvd <= w_dvd_nx;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_quot  <= w_dvd_nx;
                        r_remd  <= w_rem_nx[VW-1:0];
                        r_dbz   <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.quotient    = r_quot;
    assign bus.remainder   = r_remd;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_dbz;
endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - scoreboard bench for sequential_divider
module tb_sequential_divider;
    localparam int DW = 8;
    localparam int VW = 4;

    typedef struct packed {
        logic [DW-1:0] q;
        logic [VW-1:0] r;
        logic          z;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sequential_divider_if #(.DW(DW), .VW(VW)) bus ();

    sequential_divider #(.DW(DW), .VW(VW)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fails  = 0;
    int   done_cnt = 0;

    always @(posedge clk) if (bus.done === 1'b1) done_cnt++;

    task automatic do_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic push_exp(input logic [DW-1:0] a, input logic [VW-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q = '1;
            e.r = '0;
            e.z = 1'b1;
        end else begin
            e.q = a / b;
            e.r = VW'(a % b);
            e.z = 1'b0;
        end
        sb.push_back(e);
    endtask

    task automatic drive(input logic [DW-1:0] a, input logic [VW-1:0] b);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        push_exp(a, b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (bus.done !== 1'b1 && cyc < 30);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
            n_fails++;
            $display("FAIL reset_outputs: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        do_reset();
    endtask

    task automatic test_divide(input logic [DW-1:0] a, input logic [VW-1:0] b);
        int   cyc;
        int   d0;
        int   lat;
        exp_t e;
        do_reset();
        d0 = done_cnt;
        drive(a, b);
        wait_done(cyc);
        lat = (b == '0) ? 2 : DW + 2;
        n_checks++;
        if (cyc != lat) begin
            n_fails++;
            $display("FAIL latency %0d/%0d: got %0d cycles, want %0d", a, b, cyc, lat);
        end
        e = sb.pop_front();
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
            n_fails++;
            $display("FAIL result %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                     a, b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
        end
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || done_cnt - d0 != 1) begin
            n_fails++;
            $display("FAIL idle_after %0d/%0d: got busy=%b done=%b pulses=%0d, want 0 0 1",
                     a, b, bus.busy, bus.done, done_cnt - d0);
        end
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
            n_fails++;
            $display("FAIL hold %0d/%0d: got q=%0d r=%0d, want q=%0d r=%0d",
                     a, b, bus.quotient, bus.remainder, e.q, e.r);
        end
    endtask

    task automatic test_start_ignored();
        int   cyc;
        int   d0;
        exp_t e;
        do_reset();
        d0 = done_cnt;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = 8'd100;
        bus.divisor  = 4'd9;
        push_exp(8'd100, 4'd9);
        repeat (4) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fails++;
            $display("FAIL busy_mid: got %b, want 1", bus.busy);
        end
        bus.dividend = 8'd50;
        bus.divisor  = 4'd3;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        wait_done(cyc);
        n_checks++;
        if (cyc != 4) begin
            n_fails++;
            $display("FAIL held_start_latency: got %0d, want 4", cyc);
        end
        // start raised during DONE must be dropped without launching an op
        bus.start    = 1'b1;
        bus.dividend = 8'd7;
        bus.divisor  = 4'd2;
        @(negedge clk);
        bus.start = 1'b0;
        e = sb.pop_front();
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
            n_fails++;
            $display("FAIL held_start_result: got q=%0d r=%0d, want q=%0d r=%0d",
                     bus.quotient, bus.remainder, e.q, e.r);
        end
        repeat (6) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || done_cnt - d0 != 1 || bus.quotient !== e.q) begin
            n_fails++;
            $display("FAIL start_in_done: got busy=%b pulses=%0d q=%0d, want 0 1 %0d",
                     bus.busy, done_cnt - d0, bus.quotient, e.q);
        end
    endtask

    task automatic test_reset_midop();
        int   cyc;
        int   d0;
        exp_t e;
        drive(8'd200, 4'd7);
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero} !== '0) begin
            n_fails++;
            $display("FAIL reset_midop: got q=%0d r=%0d busy=%b done=%b dbz=%b, want all 0",
                     bus.quotient, bus.remainder, bus.busy, bus.done, bus.div_by_zero);
        end
        sb.delete();
        d0 = done_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        n_checks++;
        if (done_cnt != d0 || bus.busy !== 1'b0) begin
            n_fails++;
            $display("FAIL aborted_op: got pulses=%0d busy=%b, want 0 0", done_cnt - d0, bus.busy);
        end
        drive(8'd18, 4'd6);
        wait_done(cyc);
        e = sb.pop_front();
        n_checks++;
        if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e || cyc != DW + 2) begin
            n_fails++;
            $display("FAIL after_abort: got q=%0d r=%0d cyc=%0d, want q=%0d r=%0d cyc=%0d",
                     bus.quotient, bus.remainder, cyc, e.q, e.r, DW + 2);
        end
    endtask

    task automatic test_reset_with_start();
        int d0;
        d0           = done_cnt;
        rst          = 1'b1;
        bus.start    = 1'b1;
        bus.dividend = 8'd9;
        bus.divisor  = 4'd3;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || bus.quotient !== '0) begin
            n_fails++;
            $display("FAIL rst_and_start: got busy=%b q=%0d, want 0 0", bus.busy, bus.quotient);
        end
        rst       = 1'b0;
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++;
        if (bus.busy !== 1'b0 || done_cnt != d0) begin
            n_fails++;
            $display("FAIL rst_start_leak: got busy=%b pulses=%0d, want 0 0", bus.busy, done_cnt - d0);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] a;
        logic [VW-1:0] b;
        int            cyc;
        exp_t          e;
        logic [DW-1:0] fa[4] = '{8'd255, 8'd15, 8'd14, 8'd1};
        logic [VW-1:0] fb[4] = '{4'd15, 4'd15, 4'd15, 4'd0};
        do_reset();
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                a = fa[i];
                b = fb[i];
            end else begin
                a = DW'($urandom_range(0, 255));
                b = VW'($urandom_range(1, 15));
            end
            drive(a, b);
            wait_done(cyc);
            e = sb.pop_front();
            n_checks++;
            if ({bus.quotient, bus.remainder, bus.div_by_zero} !== e) begin
                n_fails++;
                $display("FAIL b2b %0d/%0d: got q=%0d r=%0d dbz=%b, want q=%0d r=%0d dbz=%b",
                         a, b, bus.quotient, bus.remainder, bus.div_by_zero, e.q, e.r, e.z);
            end
            if (b != '0) begin
                n_checks++;
                if (32'(bus.quotient) * 32'(b) + 32'(bus.remainder) != 32'(a) || bus.remainder >= b) begin
                    n_fails++;
                    $display("FAIL invariant %0d/%0d: got q=%0d r=%0d", a, b, bus.quotient, bus.remainder);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        test_reset();
        test_divide(8'd18, 4'd6);
        test_divide(8'd225, 4'd15);
        test_divide(8'd200, 4'd7);
        test_divide(8'd255, 4'd1);
        test_divide(8'd0, 4'd12);
        test_divide(8'd0, 4'd0);
        test_start_ignored();
        test_reset_midop();
        test_reset_with_start();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
